// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the writeback unit: FSM state encoding, CSR indices, trap causes.
package ysyx_24080014_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_WAIT_LSU,
    ST_TRAP_MEPC,
    ST_TRAP_MCAUSE
  } wbu_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/ysyx_24080014_wbu_timer.sv
// LSU wait counter: clear has priority over enable; expire flags the last waiting cycle.
module ysyx_24080014_wbu_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ysyx_24080014_wbu.sv
// Writeback unit: sole GPR/CSR writer, sequences ecall trap and mret redirect, pulses commit.
// Optional LSU wait timeout enabled by defining YSYX_24080014_LSU_TIMEOUT_EN.
module ysyx_24080014_wbu
  import ysyx_24080014_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_next_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic [XLEN-1:0] in_rd_data,
  input  logic            in_is_load,
  input  logic            in_is_ecall,
  input  logic            in_is_mret,
  input  logic            in_csr_wen,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_csr_wdata,
  input  logic            lsu_rvalid,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            gpr_wen,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] commit_next_pc,
  output logic            lsu_timeout
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] rd_data;
    logic            is_mret;
    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
  } pkt_t;

  wbu_state_e state_q, state_d, entry_state;
  pkt_t       pkt_q, pkt_d;
  logic       accept;
  logic       lsu_expire;
  logic       timeout_q, timeout_d;

  logic            gpr_wen_d, csr_wen_d, redirect_valid_d, commit_valid_d;
  logic [4:0]      gpr_waddr_d;
  logic [11:0]     csr_waddr_d;
  logic [XLEN-1:0] gpr_wdata_d, csr_wdata_d, redirect_pc_d, commit_pc_d, commit_next_pc_d;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_WB) && !pkt_q.is_mret);
  assign accept   = in_valid && in_ready;

  // Flag priority ecall > mret > load is resolved once, at accept time.
  always_comb begin
    if (in_is_ecall)      entry_state = ST_TRAP_MEPC;
    else if (in_is_mret)  entry_state = ST_WB;
    else if (in_is_load)  entry_state = ST_WAIT_LSU;
    else                  entry_state = ST_WB;
  end

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
  ysyx_24080014_wbu_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept && (entry_state == ST_WAIT_LSU)),
    .enable(state_q == ST_WAIT_LSU),
    .expire(lsu_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign lsu_expire         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE:        state_d = ST_IDLE;
      ST_WB:          state_d = ST_IDLE;
      ST_WAIT_LSU: begin
        if (lsu_rvalid) begin
          pkt_d.rd_data = lsu_rdata;
          state_d       = ST_WB;
        end else if (lsu_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_TRAP_MEPC:   state_d = ST_TRAP_MCAUSE;
      ST_TRAP_MCAUSE: state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
    if (accept) begin
      pkt_d.pc        = in_pc;
      pkt_d.next_pc   = in_next_pc;
      pkt_d.rd        = in_rd;
      pkt_d.rd_wen    = in_rd_wen;
      pkt_d.rd_data   = in_rd_data;
      pkt_d.is_mret   = in_is_mret && !in_is_ecall;
      pkt_d.csr_wen   = in_csr_wen;
      pkt_d.csr_addr  = in_csr_addr;
      pkt_d.csr_wdata = in_csr_wdata;
      state_d         = entry_state;
    end
  end

  // Outputs are computed for the state being entered and registered, so each pulse lines up with its state.
  always_comb begin
    gpr_wen_d        = 1'b0;
    gpr_waddr_d      = '0;
    gpr_wdata_d      = '0;
    csr_wen_d        = 1'b0;
    csr_waddr_d      = '0;
    csr_wdata_d      = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    commit_valid_d   = 1'b0;
    commit_pc_d      = '0;
    commit_next_pc_d = '0;
    case (state_d)
      ST_WB: begin
        if (pkt_d.rd_wen && (pkt_d.rd != '0)) begin
          gpr_wen_d   = 1'b1;
          gpr_waddr_d = pkt_d.rd;
          gpr_wdata_d = pkt_d.rd_data;
        end
        if (pkt_d.csr_wen) begin
          csr_wen_d   = 1'b1;
          csr_waddr_d = pkt_d.csr_addr;
          csr_wdata_d = pkt_d.csr_wdata;
        end
        commit_valid_d   = 1'b1;
        commit_pc_d      = pkt_d.pc;
        commit_next_pc_d = pkt_d.is_mret ? mepc_i : pkt_d.next_pc;
        if (pkt_d.is_mret) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_i;
        end
      end
      ST_TRAP_MEPC: begin
        csr_wen_d   = 1'b1;
        csr_waddr_d = CSR_MEPC;
        csr_wdata_d = pkt_d.pc;
      end
      ST_TRAP_MCAUSE: begin
        csr_wen_d        = 1'b1;
        csr_waddr_d      = CSR_MCAUSE;
        csr_wdata_d      = XLEN'(MCAUSE_ECALL_M);
        redirect_valid_d = 1'b1;
        redirect_pc_d    = mtvec_i;
        commit_valid_d   = 1'b1;
        commit_pc_d      = pkt_d.pc;
        commit_next_pc_d = mtvec_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pkt_q          <= '0;
      timeout_q      <= 1'b0;
      gpr_wen        <= 1'b0;
      gpr_waddr      <= '0;
      gpr_wdata      <= '0;
      csr_wen        <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      commit_valid   <= 1'b0;
      commit_pc      <= '0;
      commit_next_pc <= '0;
    end else begin
      state_q        <= state_d;
      pkt_q          <= pkt_d;
      timeout_q      <= timeout_d;
      gpr_wen        <= gpr_wen_d;
      gpr_waddr      <= gpr_waddr_d;
      gpr_wdata      <= gpr_wdata_d;
      csr_wen        <= csr_wen_d;
      csr_waddr      <= csr_waddr_d;
      csr_wdata      <= csr_wdata_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      commit_valid   <= commit_valid_d;
      commit_pc      <= commit_pc_d;
      commit_next_pc <= commit_next_pc_d;
    end
  end

  assign lsu_timeout = timeout_q;

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Directed bench for the writeback unit: ALU, load, ecall, mret, rd=0, CSR+rd, back-to-back, reset, timeout.
module tb_ysyx_24080014_wbu;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_next_pc, in_rd_data, in_csr_wdata;
  logic [4:0]  in_rd;
  logic        in_rd_wen, in_is_load, in_is_ecall, in_is_mret, in_csr_wen;
  logic [11:0] in_csr_addr;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata, mtvec_i, mepc_i;
  logic        gpr_wen, csr_wen, redirect_valid, commit_valid, lsu_timeout;
  logic [4:0]  gpr_waddr;
  logic [11:0] csr_waddr;
  logic [31:0] gpr_wdata, csr_wdata, redirect_pc, commit_pc, commit_next_pc;

  int unsigned total, passed;

  ysyx_24080014_wbu #(
    .XLEN          (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_next_pc(in_next_pc),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data),
    .in_is_load(in_is_load), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
    .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
    .lsu_timeout(lsu_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic rd_wen,
                       input logic [31:0] data, input logic ld, input logic ec, input logic mr,
                       input logic cw, input logic [11:0] ca, input logic [31:0] cd);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_next_pc   = pc + 32'd4;
    in_rd        = rd;
    in_rd_wen    = rd_wen;
    in_rd_data   = data;
    in_is_load   = ld;
    in_is_ecall  = ec;
    in_is_mret   = mr;
    in_csr_wen   = cw;
    in_csr_addr  = ca;
    in_csr_wdata = cd;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_is_load = 1'b0; in_is_ecall = 1'b0; in_is_mret = 1'b0;
    in_rd_wen = 1'b0; in_csr_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    lsu_rvalid = 1'b0; lsu_rdata = '0; mtvec_i = 32'h8000_1000; mepc_i = 32'h8000_0014;
    in_pc = '0; in_next_pc = '0; in_rd = '0; in_rd_data = '0; in_csr_addr = '0; in_csr_wdata = '0;
    #3;
    total++; if (gpr_wen !== 1'b0) $display("FAIL reset_gpr_wen got %b want 0", gpr_wen); else passed++;
    total++; if (csr_wen !== 1'b0) $display("FAIL reset_csr_wen got %b want 0", csr_wen); else passed++;
    total++; if (commit_valid !== 1'b0) $display("FAIL reset_commit got %b want 0", commit_valid); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect got %b want 0", redirect_valid); else passed++;
    total++; if (lsu_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", lsu_timeout); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    #20;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    drive(32'h8000_0000, 5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    total++; if (gpr_wen !== 1'b1) $display("FAIL alu_wen got %b want 1", gpr_wen); else passed++;
    total++; if (gpr_waddr !== 5'd5) $display("FAIL alu_waddr got %0d want 5", gpr_waddr); else passed++;
    total++; if (gpr_wdata !== 32'h1234) $display("FAIL alu_wdata got %h want 00001234", gpr_wdata); else passed++;
    total++; if (commit_valid !== 1'b1) $display("FAIL alu_commit got %b want 1", commit_valid); else passed++;
    total++; if (commit_pc !== 32'h8000_0000) $display("FAIL alu_commit_pc got %h want 80000000", commit_pc); else passed++;
    total++; if (commit_next_pc !== 32'h8000_0004) $display("FAIL alu_next_pc got %h want 80000004", commit_next_pc); else passed++;
    total++; if (csr_wen !== 1'b0) $display("FAIL alu_csr_wen got %b want 0", csr_wen); else passed++;
    step();
    total++; if (gpr_wen !== 1'b0 || commit_valid !== 1'b0) $display("FAIL alu_pulse_end got wen=%b commit=%b want 0/0", gpr_wen, commit_valid); else passed++;
  endtask

  task automatic test_load();
    drive(32'h8000_0004, 5'd10, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL load_wait_ready got %b want 0", in_ready); else passed++;
      total++; if (gpr_wen !== 1'b0 || commit_valid !== 1'b0) $display("FAIL load_wait_quiet got wen=%b commit=%b want 0/0", gpr_wen, commit_valid); else passed++;
      step();
    end
    lsu_rvalid = 1'b1; lsu_rdata = 32'hdead_beef;
    step();
    lsu_rvalid = 1'b0;
    total++; if (gpr_wen !== 1'b1) $display("FAIL load_wen got %b want 1", gpr_wen); else passed++;
    total++; if (gpr_waddr !== 5'd10) $display("FAIL load_waddr got %0d want 10", gpr_waddr); else passed++;
    total++; if (gpr_wdata !== 32'hdead_beef) $display("FAIL load_wdata got %h want deadbeef", gpr_wdata); else passed++;
    total++; if (commit_pc !== 32'h8000_0004) $display("FAIL load_commit_pc got %h want 80000004", commit_pc); else passed++;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL load_back_idle got %b want 1", in_ready); else passed++;
    lsu_rvalid = 1'b1; lsu_rdata = 32'h1111_2222;
    step();
    lsu_rvalid = 1'b0;
    total++; if (gpr_wen !== 1'b0 || commit_valid !== 1'b0) $display("FAIL stray_rvalid got wen=%b commit=%b want 0/0", gpr_wen, commit_valid); else passed++;
  endtask

  task automatic test_ecall();
    drive(32'h8000_0010, 5'd3, 1'b1, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    total++; if (csr_wen !== 1'b1 || csr_waddr !== 12'h341) $display("FAIL ecall_mepc_addr got wen=%b addr=%h want 1/341", csr_wen, csr_waddr); else passed++;
    total++; if (csr_wdata !== 32'h8000_0010) $display("FAIL ecall_mepc_data got %h want 80000010", csr_wdata); else passed++;
    total++; if (redirect_valid !== 1'b0 || commit_valid !== 1'b0 || gpr_wen !== 1'b0) $display("FAIL ecall_mepc_quiet got rd=%b cm=%b gw=%b want 0/0/0", redirect_valid, commit_valid, gpr_wen); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL ecall_ready got %b want 0", in_ready); else passed++;
    step();
    total++; if (csr_wen !== 1'b1 || csr_waddr !== 12'h342) $display("FAIL ecall_mcause_addr got wen=%b addr=%h want 1/342", csr_wen, csr_waddr); else passed++;
    total++; if (csr_wdata !== 32'd11) $display("FAIL ecall_mcause_data got %h want 0000000b", csr_wdata); else passed++;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_1000) $display("FAIL ecall_redirect got %b/%h want 1/80001000", redirect_valid, redirect_pc); else passed++;
    total++; if (commit_valid !== 1'b1 || commit_next_pc !== 32'h8000_1000) $display("FAIL ecall_commit got %b/%h want 1/80001000", commit_valid, commit_next_pc); else passed++;
    total++; if (gpr_wen !== 1'b0) $display("FAIL ecall_no_gpr got %b want 0", gpr_wen); else passed++;
    step();
    total++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ecall_done got rd=%b ready=%b want 0/1", redirect_valid, in_ready); else passed++;
  endtask

  task automatic test_mret_rd0();
    drive(32'h8000_0020, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0014) $display("FAIL mret_redirect got %b/%h want 1/80000014", redirect_valid, redirect_pc); else passed++;
    total++; if (commit_valid !== 1'b1 || commit_next_pc !== 32'h8000_0014) $display("FAIL mret_commit got %b/%h want 1/80000014", commit_valid, commit_next_pc); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL mret_ready got %b want 0", in_ready); else passed++;
    step();
    total++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mret_done got rd=%b ready=%b want 0/1", redirect_valid, in_ready); else passed++;
    drive(32'h8000_0030, 5'd0, 1'b1, 32'hff, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    total++; if (gpr_wen !== 1'b0) $display("FAIL rd0_wen got %b want 0", gpr_wen); else passed++;
    total++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0030) $display("FAIL rd0_commit got %b/%h want 1/80000030", commit_valid, commit_pc); else passed++;
    step();
  endtask

  task automatic test_csr_and_rd();
    drive(32'h8000_0040, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300, 32'h88);
    step();
    idle();
    total++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd7 || gpr_wdata !== 32'h77) $display("FAIL csrrd_gpr got %b/%0d/%h want 1/7/00000077", gpr_wen, gpr_waddr, gpr_wdata); else passed++;
    total++; if (csr_wen !== 1'b1 || csr_waddr !== 12'h300 || csr_wdata !== 32'h88) $display("FAIL csrrd_csr got %b/%h/%h want 1/300/00000088", csr_wen, csr_waddr, csr_wdata); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int unsigned writes;
    writes = 0;
    drive(32'h8000_0100, 5'd1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (gpr_wen === 1'b1) writes++;
      total++; if (gpr_waddr !== 5'(i + 1) || gpr_wdata !== 32'h100 + 32'(i)) $display("FAIL b2b_data[%0d] got %0d/%h want %0d/%h", i, gpr_waddr, gpr_wdata, i + 1, 32'h100 + 32'(i)); else passed++;
      total++; if (commit_pc !== 32'h8000_0100 + 32'(4 * i)) $display("FAIL b2b_pc[%0d] got %h want %h", i, commit_pc, 32'h8000_0100 + 32'(4 * i)); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); else passed++;
      if (i < 3) drive(32'h8000_0104 + 32'(4 * i), 5'(i + 2), 1'b1, 32'h101 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      else idle();
    end
    total++; if (writes !== 4) $display("FAIL b2b_count got %0d want 4", writes); else passed++;
    step();
  endtask

  task automatic test_reset_mid_load();
    drive(32'h8000_0200, 5'd12, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    step();
    rst_n = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1 || gpr_wen !== 1'b0) $display("FAIL rst_mid_state got ready=%b wen=%b want 1/0", in_ready, gpr_wen); else passed++;
    rst_n = 1'b1;
    lsu_rvalid = 1'b1; lsu_rdata = 32'hcafe_f00d;
    step();
    lsu_rvalid = 1'b0;
    total++; if (gpr_wen !== 1'b0 || commit_valid !== 1'b0) $display("FAIL rst_mid_nowrite got wen=%b commit=%b want 0/0", gpr_wen, commit_valid); else passed++;
  endtask

  task automatic test_timeout();
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
    int unsigned waited;
    logic        saw_commit;
    waited = 0;
    saw_commit = 1'b0;
    drive(32'h8000_0300, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    idle();
    while (in_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
      if (commit_valid === 1'b1 || gpr_wen === 1'b1) saw_commit = 1'b1;
    end
    total++; if (waited !== 8) $display("FAIL timeout_cycles got %0d want 8", waited); else passed++;
    total++; if (lsu_timeout !== 1'b1) $display("FAIL timeout_flag got %b want 1", lsu_timeout); else passed++;
    total++; if (saw_commit !== 1'b0) $display("FAIL timeout_nocommit got %b want 0", saw_commit); else passed++;
    step();
    total++; if (lsu_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", lsu_timeout); else passed++;
`else
    total++; if (lsu_timeout !== 1'b0) $display("FAIL timeout_tied got %b want 0", lsu_timeout); else passed++;
`endif
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_alu();
    test_load();
    test_ecall();
    test_mret_rd0();
    test_csr_and_rd();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
